// File: rtl/lsu_mem_arbiter_if.sv
// Bus bundle between the LSUs, the arbiter and the data-memory controller.
// Modport master is the arbiter's view; slave is the LSU/memory side.
interface lsu_mem_arbiter_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 32,
    parameter int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
);
    logic [NUM_CHANNELS-1:0]           ch_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address;
    logic [NUM_CHANNELS-1:0]           ch_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data;
    logic [NUM_CHANNELS-1:0]           ch_write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data;
    logic [NUM_CHANNELS-1:0]           ch_write_ready;
    logic                              mem_read_valid;
    logic [ADDR_BITS-1:0]              mem_read_address;
    logic                              mem_read_ready;
    logic [DATA_BITS-1:0]              mem_read_data;
    logic                              mem_write_valid;
    logic [ADDR_BITS-1:0]              mem_write_address;
    logic [DATA_BITS-1:0]              mem_write_data;
    logic                              mem_write_ready;
    logic                              arb_error;
    logic [CH_BITS-1:0]                arb_error_channel;

    modport master (
        input  ch_read_valid, ch_read_address, ch_write_valid, ch_write_address, ch_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output ch_read_ready, ch_read_data, ch_write_ready,
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        output arb_error, arb_error_channel
    );

    modport slave (
        output ch_read_valid, ch_read_address, ch_write_valid, ch_write_address, ch_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  ch_read_ready, ch_read_data, ch_write_ready,
        input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        input  arb_error, arb_error_channel
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_CHANNELS LSUs, one transaction at a time.
// Optional ARB_WAIT timeout with sticky error flag: define LSU_ARB_TIMEOUT_EN.
//
//  state       | meaning
//  ARB_IDLE    | scan from rr_ptr+1 for a pending channel, latch its request
//  ARB_WAIT    | memory request held until the matching ready (or timeout)
//  ARB_RELEASE | guard cycle while the ready pulse drops; no grant
module lsu_mem_arbiter #(
    parameter int NUM_CHANNELS   = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    lsu_mem_arbiter_if.master bus
);
    localparam int N  = NUM_CHANNELS;
    localparam int A  = ADDR_BITS;
    localparam int D  = DATA_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (NUM_CHANNELS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("lsu_mem_arbiter: NUM_CHANNELS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    arb_state_e     state_q, state_d;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  gnt_q, gnt_d;
    logic           op_wr_q, op_wr_d;
    logic [A-1:0]   addr_q, addr_d;
    logic [D-1:0]   wdata_q, wdata_d;
    logic           mem_rv_q, mem_rv_d;
    logic           mem_wv_q, mem_wv_d;
    logic [N-1:0]   rd_rdy_q, rd_rdy_d;
    logic [N-1:0]   wr_rdy_q, wr_rdy_d;
    logic [N*D-1:0] rdata_q, rdata_d;

    logic [N-1:0]   pending;
    logic [CW-1:0]  win;
    logic           found;
    int             idx;
    logic           mem_done;
    logic           timeout;

`ifdef LSU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           err_q, err_d;
    logic [CW-1:0]  err_ch_q, err_ch_d;

    assign timeout = (tmr_q == '0);
`else
    assign timeout = 1'b0;
`endif

    assign pending  = bus.ch_read_valid | bus.ch_write_valid;
    // Only the ready of the op in flight counts.
    assign mem_done = op_wr_q ? bus.mem_write_ready : bus.mem_read_ready;

    always_comb begin : rr_scan
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!found && pending[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:    if (found) state_d = ARB_WAIT;
            ARB_WAIT:    if (mem_done || timeout) state_d = ARB_RELEASE;
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_comb begin : datapath_next
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_rv_d = mem_rv_q;
        mem_wv_d = mem_wv_q;
        rd_rdy_d = '0;
        wr_rdy_d = '0;
        rdata_d  = rdata_q;
`ifdef LSU_ARB_TIMEOUT_EN
        tmr_d    = tmr_q;
        err_d    = err_q;
        err_ch_d = err_ch_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    gnt_d   = win;
                    op_wr_d = ~bus.ch_read_valid[win];
                    // A read on the same channel goes first; the write stays pending.
                    if (bus.ch_read_valid[win]) begin
                        addr_d   = bus.ch_read_address[int'(win)*A +: A];
                        mem_rv_d = 1'b1;
                    end else begin
                        addr_d   = bus.ch_write_address[int'(win)*A +: A];
                        wdata_d  = bus.ch_write_data[int'(win)*D +: D];
                        mem_wv_d = 1'b1;
                    end
`ifdef LSU_ARB_TIMEOUT_EN
                    tmr_d = TW'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            ARB_WAIT: begin
                if (mem_done || timeout) begin
                    mem_rv_d = 1'b0;
                    mem_wv_d = 1'b0;
                    rr_ptr_d = gnt_q;
                    if (op_wr_q) begin
                        wr_rdy_d[gnt_q] = 1'b1;
                    end else begin
                        rd_rdy_d[gnt_q] = 1'b1;
                        rdata_d[int'(gnt_q)*D +: D] = mem_done ? bus.mem_read_data : '0;
                    end
`ifdef LSU_ARB_TIMEOUT_EN
                    if (!mem_done) begin
                        err_d    = 1'b1;
                        err_ch_d = gnt_q;
                    end
`endif
                end
`ifdef LSU_ARB_TIMEOUT_EN
                else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : datapath_reg
        if (!reset) begin
            rr_ptr_q <= CW'(N - 1);
            gnt_q    <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_rv_q <= 1'b0;
            mem_wv_q <= 1'b0;
            rd_rdy_q <= '0;
            wr_rdy_q <= '0;
            rdata_q  <= '0;
`ifdef LSU_ARB_TIMEOUT_EN
            tmr_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_rv_q <= mem_rv_d;
            mem_wv_q <= mem_wv_d;
            rd_rdy_q <= rd_rdy_d;
            wr_rdy_q <= wr_rdy_d;
            rdata_q  <= rdata_d;
`ifdef LSU_ARB_TIMEOUT_EN
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
`endif
        end
    end

    assign bus.mem_read_valid    = mem_rv_q;
    assign bus.mem_read_address  = addr_q;
    assign bus.mem_write_valid   = mem_wv_q;
    assign bus.mem_write_address = addr_q;
    assign bus.mem_write_data    = wdata_q;
    assign bus.ch_read_ready     = rd_rdy_q;
    assign bus.ch_write_ready    = wr_rdy_q;
    assign bus.ch_read_data      = rdata_q;
`ifdef LSU_ARB_TIMEOUT_EN
    assign bus.arb_error         = err_q;
    assign bus.arb_error_channel = err_ch_q;
`else
    assign bus.arb_error         = 1'b0;
    assign bus.arb_error_channel = '0;
`endif
endmodule
